// File: rtl/conv_seq_ctrl.sv
// Sequencer: buffers CPU-pushed words, loads them into an accelerator, starts it, polls for
// completion and captures the result. Define CONV_SEQ_TIMEOUT_EN to bound the polling phase.
module conv_seq_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [5:0]  ACC_CTRL_ADDR  = 6'h20,
  parameter logic [5:0]  ACC_STAT_ADDR  = 6'h21,
  parameter logic [5:0]  ACC_RES_ADDR   = 6'h22,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        cpu_clk_g,
  input  logic        reset_button,
  input  logic        cpu_en_i,
  input  logic        cpu_we_i,
  input  logic [2:0]  cpu_addr_i,
  input  logic [31:0] cpu_din_i,
  output logic [31:0] cpu_dout_o,
  output logic        acc_en_o,
  output logic        acc_we_o,
  output logic [5:0]  acc_addr_o,
  output logic [31:0] acc_din_o,
  input  logic [31:0] acc_dout_i,
  output logic        irq_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StPollReq, StPollWait, StReadReq, StReadWait, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  count_q;
  logic [31:0] result_q, result_d;
  logic [31:0] cpu_dout_q;
  logic        done_q, err_q;
  logic        timeout_flag;

  logic [31:0]     fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;

  logic cpu_wr, cpu_rd, ctrl_wr, go, clr, push_req, push_ok, pop;
  logic busy, fifo_full, go_ok, to_set;

  assign cpu_wr    = cpu_en_i & cpu_we_i;
  assign cpu_rd    = cpu_en_i & ~cpu_we_i;
  assign ctrl_wr   = cpu_wr & (cpu_addr_i == 3'd0);
  assign clr       = ctrl_wr & cpu_din_i[1];
  // CLR takes precedence over GO in the same write
  assign go        = ctrl_wr & cpu_din_i[0] & ~cpu_din_i[1];
  assign push_req  = cpu_wr & (cpu_addr_i == 3'd2);
  assign busy      = (state_q != StIdle);
  assign fifo_full = (level_q == LvlW'(FIFO_DEPTH));
  assign push_ok   = push_req & ~fifo_full & ~busy;
  assign pop       = (state_q == StLoad) & ~clr;
  assign go_ok     = go & ~busy & (count_q != 5'd0) & (32'(count_q) <= FIFO_DEPTH) &
                     (32'(count_q) <= 32'(level_q));

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int unsigned PcW = $clog2(TIMEOUT_CYCLES + 1);
  logic [PcW-1:0] poll_cnt_q, poll_cnt_d;
  logic           timeout_q;
  assign timeout_flag = timeout_q;
  assign irq_o        = done_q | timeout_q;
`else
  assign timeout_flag = 1'b0;
  assign irq_o        = done_q;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    result_d   = result_q;
    to_set     = 1'b0;
    acc_en_o   = 1'b0;
    acc_we_o   = 1'b0;
    acc_addr_o = 6'h00;
    acc_din_o  = 32'h0;
`ifdef CONV_SEQ_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (go_ok) begin
          state_d = StLoad;
          idx_d   = 5'd0;
        end
      end
      StLoad: begin
        acc_en_o   = 1'b1;
        acc_we_o   = 1'b1;
        acc_addr_o = 6'(idx_q);
        acc_din_o  = fifo_mem[rd_ptr_q];
        if (idx_q == count_q - 5'd1) state_d = StStart;
        else                         idx_d   = idx_q + 5'd1;
      end
      StStart: begin
        acc_en_o   = 1'b1;
        acc_we_o   = 1'b1;
        acc_addr_o = ACC_CTRL_ADDR;
        acc_din_o  = 32'h1;
        state_d    = StPollReq;
`ifdef CONV_SEQ_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
      end
      StPollReq: begin
        acc_en_o   = 1'b1;
        acc_addr_o = ACC_STAT_ADDR;
        state_d    = StPollWait;
      end
      StPollWait: begin
        state_d = acc_dout_i[0] ? StReadReq : StPollReq;
      end
      StReadReq: begin
        acc_en_o   = 1'b1;
        acc_addr_o = ACC_RES_ADDR;
        state_d    = StReadWait;
      end
      StReadWait: begin
        result_d = acc_dout_i;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef CONV_SEQ_TIMEOUT_EN
    if (state_q == StPollReq || state_q == StPollWait) begin
      poll_cnt_d = poll_cnt_q + PcW'(1);
      // A completion seen on the final poll cycle still wins over the timeout
      if (32'(poll_cnt_q) == TIMEOUT_CYCLES - 1 && state_d != StReadReq) begin
        state_d = StDone;
        to_set  = 1'b1;
      end
    end
`endif
    if (clr) state_d = StIdle;
  end

  always_ff @(posedge cpu_clk_g or posedge reset_button) begin
    if (reset_button) begin
      state_q    <= StIdle;
      idx_q      <= 5'd0;
      count_q    <= 5'd0;
      result_q   <= 32'h0;
      cpu_dout_q <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      if (cpu_wr && cpu_addr_i == 3'd1 && !busy) count_q <= cpu_din_i[4:0];
      if (clr || go_ok)           done_q <= 1'b0;
      else if (state_q == StDone) done_q <= 1'b1;
      if (clr) err_q <= 1'b0;
      else if ((push_req && (fifo_full || busy)) || (go && !go_ok)) err_q <= 1'b1;
      if (cpu_rd) begin
        case (cpu_addr_i)
          3'd0:    cpu_dout_q <= {28'b0, err_q, timeout_flag, done_q, busy};
          3'd1:    cpu_dout_q <= {27'b0, count_q};
          3'd3:    cpu_dout_q <= result_q;
          3'd4:    cpu_dout_q <= 32'(level_q);
          default: cpu_dout_q <= 32'h0;
        endcase
      end
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  always_ff @(posedge cpu_clk_g or posedge reset_button) begin
    if (reset_button) begin
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      if (clr || go_ok) timeout_q <= 1'b0;
      else if (to_set)  timeout_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge cpu_clk_g or posedge reset_button) begin
    if (reset_button) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Pointers are PtrW bits wide, so increments wrap modulo FIFO_DEPTH
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_g) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= cpu_din_i;
  end

  assign cpu_dout_o = cpu_dout_q;

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning input FIFO entries (power of 2, ≥2).
REQ-002 SHALL have parameter ACC_CTRL_ADDR, default 6'h20, meaning the accelerator start register word address.
REQ-003 SHALL have parameter ACC_STAT_ADDR, default 6'h21, meaning the accelerator status register (bit0=done).
REQ-004 SHALL have parameter ACC_RES_ADDR, default 6'h22, meaning the accelerator result register.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the poll cycle limit.
REQ-006 cpu_clk_g  in  1  clock; all logic rising-edge.
REQ-007 reset_button  in  1  reset, asynchronous, active-high.
REQ-008 cpu_en in 1, cpu_we in 1, cpu_addr in 3, cpu_din in 32: CPU register access, single-cycle strobe.
REQ-009 cpu_dout  out  32  read data, valid one cycle after the cpu_en read.
REQ-010 acc_en out 1, acc_we out 1, acc_addr out 6, acc_din out 32: accelerator port drive.
REQ-011 acc_dout  in  32  accelerator read data, valid one cycle after the acc_en read.
REQ-012 irq  out  1  completion interrupt (see Configuration).

Function
REQ-013 SHALL decode cpu_addr as follows: 0 CTRL (W bit0 GO, bit1 CLR; R {28'b0, err, timeout, done, busy}); 1 COUNT (RW, bits[4:0]); 2 PUSH (W, FIFO write); 3 RESULT (R); 4 LEVEL (R, FIFO occupancy).
REQ-014 SHALL ignore PUSH when the FIFO is full or busy=1, and SHALL set err sticky in that case.
REQ-015 GO SHALL start a job only if idle, 1≤COUNT≤FIFO_DEPTH, and COUNT≤LEVEL; otherwise it SHALL set err and stay IDLE.
REQ-016 FSM states: IDLE, LOAD, START, POLL_REQ, POLL_WAIT, READ_REQ, READ_WAIT, DONE.
REQ-017 In LOAD, the block SHALL pop one word per cycle and write it to acc_addr=index (0..COUNT-1) with acc_en=acc_we=1, for COUNT cycles.
REQ-018 START SHALL write 32'h1 to ACC_CTRL_ADDR for one cycle.
REQ-019 POLL_REQ SHALL read ACC_STAT_ADDR; POLL_WAIT SHALL sample acc_dout[0], going to READ_REQ if 1, else to POLL_REQ.
REQ-020 READ_REQ SHALL read ACC_RES_ADDR; READ_WAIT SHALL latch acc_dout into RESULT; then the FSM SHALL enter DONE.
REQ-021 DONE SHALL set the done flag, clear busy, and return to IDLE in the next cycle.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 acc_en SHALL be 0 in IDLE and DONE; the CPU SHALL have no direct accelerator access.
REQ-024 GO on a new job SHALL clear done and timeout; err SHALL be cleared only by CLR.
REQ-025 CLR SHALL clear done, timeout, err and flush the FIFO; if busy, it SHALL abort to IDLE on the next cycle with acc_en=0.
REQ-026 When GO and CLR occur in the same write, CLR SHALL win and no job SHALL start.
REQ-027 On a simultaneous PUSH and pop, LEVEL SHALL be unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Job latency SHALL be COUNT+1+2·polls+2+1 cycles from GO to done=1.

Reset
REQ-029 Reset SHALL set the FSM to IDLE; FIFO empty; COUNT=0; RESULT=0; busy, done, timeout, err=0; cpu_dout=0; acc_en, acc_we=0; acc_addr=0; acc_din=0; irq=0.
REQ-030 Reset asserted mid-job SHALL abandon the job immediately, with no further accelerator writes after deassertion.

Configuration
REQ-031 Macro CONV_SEQ_TIMEOUT_EN defined: a poll counter SHALL count POLL cycles; on reaching TIMEOUT_CYCLES it SHALL set timeout, leave RESULT unchanged, and go to DONE (done=1); irq=done|timeout.
REQ-032 Macro CONV_SEQ_TIMEOUT_EN undefined: polling SHALL be unbounded, the timeout bit SHALL read 0, and irq=done.

Verification
REQ-033 COUNT=9, push 9 words 1..9, GO; stub done after 3 polls, result 32'h2D -> acc writes addr 0..8 with data 1..9, start write, RESULT=32'h2D, CTRL reads 0x2.
REQ-034 Push 17 words with FIFO_DEPTH=16 -> LEVEL=16, err=1, 17th word is never written to the accelerator.
REQ-035 COUNT=5, LEVEL=3, GO -> err=1, busy stays 0, acc_en never asserted.
REQ-036 CLR written during POLL -> next cycle busy=0, acc_en=0, LEVEL=0, done=0.
REQ-037 With CONV_SEQ_TIMEOUT_EN, stub never done -> after 4096 poll cycles timeout=1, done=1, irq=1, RESULT unchanged.
REQ-038 reset_button pulsed in LOAD -> all outputs at reset values asynchronously; no acc_we after release.
